// File: rtl/rriscv_pkg.sv
// Shared core constants and inter-stage bundles.
// Operand fetch uses XLEN, AW and operand_t.
package rriscv_pkg;

    localparam int XLEN = 32;
    localparam int AW   = $clog2(XLEN);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [AW-1:0]   rd;
        logic            we;
    } operand_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Issue, register file, writeback and operand handshake bundle.
// master = surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if;
    import rriscv_pkg::*;

    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [AW-1:0]   issue_rs1_i;
    logic [AW-1:0]   issue_rs2_i;
    logic [AW-1:0]   issue_rd_i;
    logic            issue_we_i;

    logic [AW-1:0]   rf_raddr_a_o;
    logic [AW-1:0]   rf_raddr_b_o;
    logic [XLEN-1:0] rf_data_a_i;
    logic [XLEN-1:0] rf_data_b_i;

    logic            wb_valid_i;
    logic [AW-1:0]   wb_addr_i;
    logic [XLEN-1:0] wb_data_i;

    logic            op_valid_o;
    logic            op_ready_i;
    logic [XLEN-1:0] op_a_o;
    logic [XLEN-1:0] op_b_o;
    logic [AW-1:0]   op_rd_o;
    logic            op_we_o;

    modport master (
        output issue_valid_i, issue_rs1_i, issue_rs2_i,
        output issue_rd_i, issue_we_i,
        input  issue_ready_o,
        input  rf_raddr_a_o, rf_raddr_b_o,
        output rf_data_a_i, rf_data_b_i,
        output wb_valid_i, wb_addr_i, wb_data_i,
        input  op_valid_o, op_a_o, op_b_o, op_rd_o, op_we_o,
        output op_ready_i
    );

    modport slave (
        input  issue_valid_i, issue_rs1_i, issue_rs2_i,
        input  issue_rd_i, issue_we_i,
        output issue_ready_o,
        output rf_raddr_a_o, rf_raddr_b_o,
        input  rf_data_a_i, rf_data_b_i,
        input  wb_valid_i, wb_addr_i, wb_data_i,
        output op_valid_o, op_a_o, op_b_o, op_rd_o, op_we_o,
        input  op_ready_i
    );

endinterface

// File: rtl/operand_bypass.sv
// Per-source operand select: x0, writeback forward, then register file.
module operand_bypass #(
    parameter int XLEN = rriscv_pkg::XLEN,
    parameter int AW   = rriscv_pkg::AW
) (
    input  logic [AW-1:0]   rs_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            wb_live_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o
);

    always_comb begin
        data_o = rf_data_i;
        unique case (1'b1)
            (rs_i == '0):
                data_o = '0;
            (wb_live_i && wb_addr_i == rs_i):
                data_o = wb_data_i;
            default:
                data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard hazard check, writeback bypass
// and a single output operand register.
module operand_fetch #(
    parameter int XLEN = rriscv_pkg::XLEN
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            halt_i,
    input  logic            flush_i,
    operand_fetch_if.slave  bus,
    output logic [XLEN-1:0] busy_o
);
    import rriscv_pkg::*;

    logic [AW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] opnd_a, opnd_b;
    logic [XLEN-1:0] busy_q, busy_d, set_vec, clr_vec;
    logic            wb_live, fwd1, fwd2, wb_clears_rd;
    logic            hazard, ready, accept;
    logic            op_valid_q;
    operand_t        op_q, op_d;

    assign rs1 = bus.issue_rs1_i;
    assign rs2 = bus.issue_rs2_i;
    assign rd  = bus.issue_rd_i;

    assign bus.rf_raddr_a_o = rs1;
    assign bus.rf_raddr_b_o = rs2;

    // The register file drops writes while halted, so bypass must too.
    assign wb_live = bus.wb_valid_i & ~halt_i;

    operand_bypass #(.XLEN(XLEN), .AW(AW)) u_byp_a (
        .rs_i      (rs1),
        .rf_data_i (bus.rf_data_a_i),
        .wb_live_i (wb_live),
        .wb_addr_i (bus.wb_addr_i),
        .wb_data_i (bus.wb_data_i),
        .data_o    (opnd_a)
    );

    operand_bypass #(.XLEN(XLEN), .AW(AW)) u_byp_b (
        .rs_i      (rs2),
        .rf_data_i (bus.rf_data_b_i),
        .wb_live_i (wb_live),
        .wb_addr_i (bus.wb_addr_i),
        .wb_data_i (bus.wb_data_i),
        .data_o    (opnd_b)
    );

    assign fwd1         = bus.wb_valid_i & (bus.wb_addr_i == rs1);
    assign fwd2         = bus.wb_valid_i & (bus.wb_addr_i == rs2);
    assign wb_clears_rd = bus.wb_valid_i & (bus.wb_addr_i == rd);

    assign hazard = (busy_q[rs1] & ~fwd1)
                  | (busy_q[rs2] & ~fwd2)
                  | (bus.issue_we_i & busy_q[rd] & ~wb_clears_rd);

    assign ready  = ~halt_i & ~flush_i & ~hazard
                  & (~op_valid_q | bus.op_ready_i);
    assign accept = bus.issue_valid_i & ready;

    always_comb begin
        op_d    = '{a: opnd_a, b: opnd_b, rd: rd, we: bus.issue_we_i};
        set_vec = '0;
        clr_vec = '0;
        if (accept && bus.issue_we_i && rd != '0)
            set_vec[rd] = 1'b1;
        if (bus.wb_valid_i && bus.wb_addr_i != '0)
            clr_vec[bus.wb_addr_i] = 1'b1;
        // Set is applied after clear so a same-cycle re-issue stays busy.
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_valid_q <= 1'b0;
            op_q       <= '0;
            busy_q     <= '0;
        end else if (halt_i) begin
            op_valid_q <= op_valid_q;
        end else if (flush_i) begin
            op_valid_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            if (accept) begin
                op_valid_q <= 1'b1;
                op_q       <= op_d;
            end else if (bus.op_ready_i) begin
                op_valid_q <= 1'b0;
            end
            busy_q <= busy_d;
        end
    end

    assign bus.issue_ready_o = ready;
    assign bus.op_valid_o    = op_valid_q;
    assign bus.op_a_o        = op_q.a;
    assign bus.op_b_o        = op_q.b;
    assign bus.op_rd_o       = op_q.rd;
    assign bus.op_we_o       = op_q.we;
    assign busy_o            = busy_q;

endmodule
